// File: rtl/fir_channel_scheduler.sv
// +----------------------------------------------------------------------------+
// | fir_channel_scheduler                                                      |
// | Round-robin sharing of one multichannel FIR among NCH strobed sources.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module fir_channel_scheduler #(
  parameter int NCH = 8,
  parameter int DW  = 24,
  parameter int UW  = 3
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_arstn,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_strobe,
  input  logic [NCH-1:0]    ch_enable,
  input  logic              ovr_clear,
  output logic [DW-1:0]     m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [UW-1:0]     m_axis_tuser,
  output logic [NCH-1:0]    pending,
  output logic [NCH-1:0]    overrun
);

  logic [DW-1:0]  r_hold [NCH];
  logic [NCH-1:0] r_pending;
  logic [NCH-1:0] r_overrun;
  logic           r_tvalid;
  logic [DW-1:0]  r_tdata;
  logic [UW-1:0]  r_tuser;
  logic [UW-1:0]  r_rr_ptr;

  logic [NCH-1:0] w_req;
  logic [NCH-1:0] w_strb;
  logic [NCH-1:0] w_drain;
  logic [NCH-1:0] w_ovr_set;
  logic [NCH-1:0] w_capture;
  logic           w_load;
  logic           w_accept;
  logic           w_found;
  logic [UW-1:0]  w_grant;
  logic [UW-1:0]  w_idx;
  logic [UW:0]    w_sum;
  logic [UW-1:0]  w_rr_next;

  assign w_req    = r_pending & ch_enable;
  assign w_accept = r_tvalid & m_axis_tready;
  assign w_load   = (~r_tvalid | m_axis_tready) & (|w_req);

  // Scan from rr_ptr upward, wrapping at NCH rather than 2**UW.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    w_sum   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (UW+1)'(i);
      if (w_sum >= (UW+1)'(NCH))
        w_sum = w_sum - (UW+1)'(NCH);
      w_idx = w_sum[UW-1:0];
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_rr_next = (w_grant == UW'(NCH-1)) ? '0 : w_grant + UW'(1);
  assign w_drain   = w_load ? (NCH'(1) << w_grant) : '0;

  // A strobe on the drain cycle refills the slot; otherwise the oldest sample wins.
  assign w_strb    = in_strobe & ch_enable;
  assign w_ovr_set = w_strb & r_pending & ~w_drain;
  assign w_capture = w_strb & ~w_ovr_set;

  for (genvar k = 0; k < NCH; k++) begin : g_hold
    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
      if (!s_axis_arstn)
        r_hold[k] <= '0;
      else if (w_capture[k])
        r_hold[k] <= in_data[k*DW +: DW];
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= ch_enable & ((r_pending & ~w_drain) | w_capture);
      r_overrun <= w_ovr_set | (r_overrun & ~{NCH{ovr_clear}});
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= '0;
      r_rr_ptr <= '0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tdata  <= r_hold[w_grant];
      r_tuser  <= w_grant;
      r_rr_ptr <= w_rr_next;
    end else if (w_accept) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tuser  = r_tuser;
  assign pending       = r_pending;
  assign overrun       = r_overrun;

endmodule

`default_nettype wire
